// File: rtl/result_mem_writer.sv
`default_nettype none
// ============================================================================
//  Module   : result_mem_writer
//  Purpose  : Collects NUM_UNITS results per beat and stores them in raster
//             order into an output feature-map memory with a registered read
//             port. Optional macro RESULT_RELU_EN clamps negative results to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module result_mem_writer #(
    parameter  int DATA_WIDTH = 16,
    parameter  int OUT_WIDTH  = 7,
    parameter  int OUT_HEIGHT = 7,
    parameter  int NUM_UNITS  = 2,
    localparam int N          = OUT_WIDTH * OUT_HEIGHT,
    localparam int AW         = $clog2(N),
    localparam int CW         = $clog2(N + 1)
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic                                  in_valid,
    input  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0]  in_data,
    output logic                                  in_ready,
    input  logic [AW-1:0]                         rd_addr,
    output logic [DATA_WIDTH-1:0]                 rd_data,
    output logic [CW-1:0]                         count,
    output logic                                  done,
    output logic                                  overflow
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [CW-1:0]          r_wr_ptr;
    logic [CW-1:0]          w_wr_ptr_next;
    logic [CW:0]            w_ptr_sum;
    logic                   w_accept;
    logic [CW:0]            w_waddr [NUM_UNITS];
    logic [NUM_UNITS-1:0]   w_we;
    logic [DATA_WIDTH-1:0]  w_wdata [NUM_UNITS];
    logic [CW-1:0]          w_rd_addr_ext;
    logic [DATA_WIDTH-1:0]  r_mem [N];

    assign in_ready      = (r_state == ST_COLLECT);
    assign done          = (r_state == ST_DONE);
    assign count         = r_wr_ptr;
    // A beat coinciding with start belongs to neither frame and is dropped.
    assign w_accept      = in_valid && in_ready && !start;
    assign w_ptr_sum     = {1'b0, r_wr_ptr} + (CW+1)'(NUM_UNITS);
    assign w_rd_addr_ext = CW'(rd_addr);

    for (genvar i = 0; i < NUM_UNITS; i++) begin : g_unit
        assign w_waddr[i] = {1'b0, r_wr_ptr} + (CW+1)'(i);
        assign w_we[i]    = w_accept && (w_waddr[i] < (CW+1)'(N));
`ifdef RESULT_RELU_EN
        assign w_wdata[i] = in_data[i][DATA_WIDTH-1] ? '0 : in_data[i];
`else
        assign w_wdata[i] = in_data[i];
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_wr_ptr <= '0;
        end else begin
            r_state  <= w_state_next;
            r_wr_ptr <= w_wr_ptr_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_wr_ptr_next = r_wr_ptr;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_next  = ST_COLLECT;
                    w_wr_ptr_next = '0;
                end
            end
            ST_COLLECT: begin
                if (start) begin
                    w_wr_ptr_next = '0;
                end else if (w_accept) begin
                    if (w_ptr_sum >= (CW+1)'(N)) begin
                        w_wr_ptr_next = CW'(N);
                        w_state_next  = ST_DONE;
                    end else begin
                        w_wr_ptr_next = w_ptr_sum[CW-1:0];
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (start) begin
            overflow <= 1'b0;
        end else if (in_valid && !in_ready) begin
            overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < N; j++) begin
                r_mem[j] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                if (w_we[i]) begin
                    r_mem[w_waddr[i][AW-1:0]] <= w_wdata[i];
                end
            end
        end
    end

    // Read samples the pre-write contents, giving read-before-write ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else if (w_rd_addr_ext < CW'(N)) begin
            rd_data <= r_mem[rd_addr];
        end else begin
            rd_data <= '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_result_mem_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_result_mem_writer
//  Purpose  : Directed scoreboard bench for result_mem_writer (3x3 map, 2 units).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_result_mem_writer;

    localparam int NW = 9;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              in_valid;
    logic [1:0][15:0]  in_data;
    logic              in_ready;
    logic [3:0]        rd_addr;
    logic [15:0]       rd_data;
    logic [3:0]        count;
    logic              done;
    logic              overflow;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] mm [NW];
    int          m_ptr;
    bit          m_col, m_done, m_ovf;
    logic [15:0] sb [$];

    result_mem_writer #(
        .DATA_WIDTH (16),
        .OUT_WIDTH  (3),
        .OUT_HEIGHT (3),
        .NUM_UNITS  (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .count    (count),
        .done     (done),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] relu(input logic [15:0] v);
`ifdef RESULT_RELU_EN
        return v[15] ? 16'h0000 : v;
`else
        return v;
`endif
    endfunction

    task automatic model_clear();
        for (int j = 0; j < NW; j++) mm[j] = 16'h0000;
        m_ptr = 0; m_col = 0; m_done = 0; m_ovf = 0;
    endtask

    task automatic model_beat(input logic [15:0] d0, input logic [15:0] d1);
        if (m_col) begin
            if (m_ptr < NW)     mm[m_ptr]     = relu(d0);
            if (m_ptr + 1 < NW) mm[m_ptr + 1] = relu(d1);
            m_ptr = (m_ptr + 2 > NW) ? NW : m_ptr + 2;
            if (m_ptr == NW) begin
                m_col  = 0;
                m_done = 1;
            end
        end else begin
            m_ovf = 1;
        end
    endtask

    task automatic do_start(input bit with_beat);
        start    = 1'b1;
        in_valid = with_beat;
        in_data  = {16'h5555, 16'h5555};
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        m_ptr = 0; m_col = 1; m_done = 0; m_ovf = 0;
    endtask

    task automatic beat(input logic [15:0] d0, input logic [15:0] d1);
        in_valid = 1'b1;
        in_data  = {d1, d0};
        tick();
        in_valid = 1'b0;
        model_beat(d0, d1);
    endtask

    task automatic rd(input int a);
        logic [15:0] e;
        rd_addr = 4'(a);
        sb.push_back((a < NW) ? mm[a] : 16'h0000);
        tick();
        e = sb.pop_front();
        chk($sformatf("rd[%0d]", a), {16'h0, rd_data}, {16'h0, e});
    endtask

    task automatic rd_all();
        for (int a = 0; a < NW; a++) rd(a);
    endtask

    task automatic status(input string tag);
        chk({tag, ".in_ready"}, {31'h0, in_ready}, {31'h0, m_col});
        chk({tag, ".done"},     {31'h0, done},     {31'h0, m_done});
        chk({tag, ".count"},    {28'h0, count},    32'(m_ptr));
        chk({tag, ".overflow"}, {31'h0, overflow}, {31'h0, m_ovf});
    endtask

    initial begin
        logic [15:0] e;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; rd_addr = '0;
        model_clear();
        tick(); tick();
        reset = 1'b0;
        chk("reset.rd_data", {16'h0, rd_data}, 32'h0);
        status("reset");
        rd_all();
        rd(15);

        // in_valid while idle flags overflow, memory untouched
        beat(16'h1111, 16'h2222);
        status("idle_ovf");
        rd_all();

        // Frame 1: back-to-back beats {2k+1, 2k}
        do_start(1'b0);
        status("start1");
        for (int k = 0; k < 5; k++) begin
            beat(16'(2 * k), 16'(2 * k + 1));
            chk($sformatf("f1.done_beat%0d", k + 1), {31'h0, done}, {31'h0, m_done});
        end
        status("f1_end");
        rd_all();

        // in_valid while done flags overflow; start clears it
        beat(16'h7777, 16'h7777);
        status("done_ovf");
        rd_all();

        // Frame 2: bubbles between beats
        do_start(1'b0);
        status("start2");
        for (int k = 0; k < 5; k++) begin
            tick();
            beat(16'(2 * k), 16'(2 * k + 1));
            chk($sformatf("f2.done_beat%0d", k + 1), {31'h0, done}, {31'h0, m_done});
        end
        status("f2_end");
        rd_all();

        // Frame 3: restart after two beats; beat with start is dropped silently
        do_start(1'b0);
        beat(16'h1234, 16'h4321);
        beat(16'h1234, 16'h4321);
        status("f3_mid");
        do_start(1'b1);
        status("f3_restart");
        for (int k = 0; k < 5; k++) beat(16'h00AA, 16'h00AA);
        status("f3_end");
        rd_all();

        // Frame 4: negative value, read-before-write, then reset mid-frame
        do_start(1'b0);
        beat(16'hFFF6, 16'h0007);
        rd(0);
        rd(1);
        rd_addr  = 4'd2;
        sb.push_back(mm[2]);
        in_valid = 1'b1;
        in_data  = {16'h0033, 16'h0022};
        tick();
        in_valid = 1'b0;
        e = sb.pop_front();
        chk("rbw.old", {16'h0, rd_data}, {16'h0, e});
        model_beat(16'h0022, 16'h0033);
        rd(2);
        beat(16'h8001, 16'h0044);
        status("f4_mid");
        #2 reset = 1'b1;
        #1;
        model_clear();
        status("async_reset");
        chk("async_reset.rd_data", {16'h0, rd_data}, 32'h0);
        tick();
        reset = 1'b0;
        status("post_reset");
        rd_all();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
